fir_sample_ring: RTL and testbench



---
 rtl/fir_sample_ring_if.sv | 33 +++
 rtl/fir_sample_ring.sv | 137 +++++++++++++
 tb/tb_fir_sample_ring.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_sample_ring_if.sv
// Bundle of the sample-ring data and status signals. The master drives
// samples and the flush request; the slave (the ring) presents the window
// and its status.
// The optional FIR_SAMPLE_RING_OVERRUN_CNT_EN macro adds overrun_cnt_out.
interface fir_sample_ring_if;
  logic signed [15:0] audio_in;
  logic               audio_valid_in;
  logic               flush_in;
  logic signed [15:0] sample_out [64];
  logic [5:0]         offset_out;
  logic               ready_out;
  logic               busy_out;
  logic               overrun_out;
`ifdef FIR_SAMPLE_RING_OVERRUN_CNT_EN
  logic [15:0]        overrun_cnt_out;
`endif

  modport master (
    output audio_in, audio_valid_in, flush_in,
    input  sample_out, offset_out, ready_out, busy_out, overrun_out
`ifdef FIR_SAMPLE_RING_OVERRUN_CNT_EN
    , input overrun_cnt_out
`endif
  );

  modport slave (
    input  audio_in, audio_valid_in, flush_in,
    output sample_out, offset_out, ready_out, busy_out, overrun_out
`ifdef FIR_SAMPLE_RING_OVERRUN_CNT_EN
    , output overrun_cnt_out
`endif
  );
endinterface

// File: rtl/fir_sample_ring.sv
// 64-entry circular sample window feeding the 63-tap FIR. Each accepted
// sample is written at wptr and announced with a one-cycle ready_out pulse
// in the same cycle the updated window and offset become visible. A gap
// counter flags starts that arrive before the FIR can finish the previous
// accumulation.
// Optional: define FIR_SAMPLE_RING_OVERRUN_CNT_EN for a saturating count
// of overrun accepts on overrun_cnt_out.
//
// state   | meaning
// S_FLUSH | zeroing one entry per cycle; inputs ignored; busy_out = 1
// S_RUN   | accepting samples, issuing FIR start pulses
module fir_sample_ring #(
  parameter int DEPTH    = 64,
  parameter int MIN_GAP  = 65,
  parameter int DECIMATE = 1
) (
  input logic              clk_in,
  input logic              rst_in,
  fir_sample_ring_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam int DEC_W = 4;

  typedef enum logic {S_FLUSH, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   flush_idx_q, flush_idx_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   offset_q, offset_d;
  logic               ready_q, ready_d;
  logic               overrun_q, overrun_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [DEC_W-1:0]   dec_q, dec_d;
  logic [15:0]        ovr_cnt_q, ovr_cnt_d;
  logic signed [15:0] mem_q [DEPTH];

  logic               we;
  logic [PTR_W-1:0]   waddr;
  logic signed [15:0] wdata;

  // Next-state, write port and status logic for both states.
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    wptr_d      = wptr_q;
    offset_d    = offset_q;
    ready_d     = 1'b0;
    overrun_d   = overrun_q;
    gap_d       = (gap_q == GAP_W'(MIN_GAP)) ? gap_q : gap_q + GAP_W'(1);
    dec_d       = dec_q;
    ovr_cnt_d   = ovr_cnt_q;
    we          = 1'b0;
    waddr       = wptr_q;
    wdata       = bus.audio_in;

    case (state_q)
      S_FLUSH: begin
        we          = 1'b1;
        waddr       = flush_idx_q;
        wdata       = '0;
        flush_idx_d = flush_idx_q + PTR_W'(1);
        if (flush_idx_q == PTR_W'(DEPTH - 1)) begin
          state_d  = S_RUN;
          wptr_d   = '0;
          offset_d = PTR_W'(DEPTH - 1);
        end
      end
      S_RUN: begin
        if (bus.flush_in) begin
          // Flush wins over a coincident sample, which is dropped.
          state_d     = S_FLUSH;
          flush_idx_d = '0;
          overrun_d   = 1'b0;
          dec_d       = '0;
          ovr_cnt_d   = '0;
        end else if (bus.audio_valid_in) begin
          dec_d = (dec_q == DEC_W'(DECIMATE - 1)) ? '0 : dec_q + DEC_W'(1);
          if (dec_q == '0) begin
            we       = 1'b1;
            offset_d = wptr_q;
            wptr_d   = wptr_q + PTR_W'(1);
            ready_d  = 1'b1;
            gap_d    = GAP_W'(1);
            // The FIR is restarted regardless; the early start is only flagged.
            if (gap_q < GAP_W'(MIN_GAP)) begin
              overrun_d = 1'b1;
              if (ovr_cnt_q != 16'hFFFF) ovr_cnt_d = ovr_cnt_q + 16'd1;
            end
          end
        end
      end
      default: state_d = S_FLUSH;
    endcase
  end

  // Control registers with synchronous reset; reset restarts the flush.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_FLUSH;
      flush_idx_q <= '0;
      wptr_q      <= '0;
      offset_q    <= '0;
      ready_q     <= 1'b0;
      overrun_q   <= 1'b0;
      gap_q       <= GAP_W'(MIN_GAP);
      dec_q       <= '0;
      ovr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      wptr_q      <= wptr_d;
      offset_q    <= offset_d;
      ready_q     <= ready_d;
      overrun_q   <= overrun_d;
      gap_q       <= gap_d;
      dec_q       <= dec_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  // Window storage; not reset, the flush sequence clears it.
  always_ff @(posedge clk_in) begin
    if (we && !rst_in) mem_q[waddr] <= wdata;
  end

  assign bus.sample_out  = mem_q;
  assign bus.offset_out  = offset_q;
  assign bus.ready_out   = ready_q;
  assign bus.busy_out    = (state_q == S_FLUSH);
  assign bus.overrun_out = overrun_q;
`ifdef FIR_SAMPLE_RING_OVERRUN_CNT_EN
  assign bus.overrun_cnt_out = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_fir_sample_ring.sv
// Bench for fir_sample_ring: two instances (DECIMATE = 1 and 4) share one
// stimulus stream. An event-level model tracks each ring and is compared
// every cycle; directed literal checks pin key results.
module tb_fir_sample_ring;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [15:0] a_s;
  logic               v_s, f_s;

  fir_sample_ring_if if1 ();
  fir_sample_ring_if if4 ();

  assign if1.audio_in = a_s;  assign if1.audio_valid_in = v_s;  assign if1.flush_in = f_s;
  assign if4.audio_in = a_s;  assign if4.audio_valid_in = v_s;  assign if4.flush_in = f_s;

  fir_sample_ring #(.DECIMATE(1)) dut1 (.clk_in(clk), .rst_in(rst), .bus(if1));
  fir_sample_ring #(.DECIMATE(4)) dut4 (.clk_in(clk), .rst_in(rst), .bus(if4));

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  // ---------------- model ----------------
  int DECV [2] = '{1, 4};
  int mw [2][64];
  int m_wptr [2], m_off [2], m_busy_left [2], m_nval [2], m_last [2], m_cnt [2];
  bit m_ready [2], m_ovr [2];
  bit m_init = 0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_ready[d] = 0;
      if (rst) begin
        m_busy_left[d] = 64;
        for (int i = 0; i < 64; i++) mw[d][i] = 0;
        m_off[d] = 0; m_wptr[d] = 0; m_ovr[d] = 0; m_cnt[d] = 0;
        m_nval[d] = 0; m_last[d] = -1000;
      end else if (m_busy_left[d] > 0) begin
        m_busy_left[d]--;
        if (m_busy_left[d] == 0) begin m_wptr[d] = 0; m_off[d] = 63; end
      end else if (f_s) begin
        m_busy_left[d] = 64;
        for (int i = 0; i < 64; i++) mw[d][i] = 0;
        m_ovr[d] = 0; m_cnt[d] = 0; m_nval[d] = 0;
      end else if (v_s) begin
        if (m_nval[d] == 0) begin
          if (cyc - m_last[d] < 65) begin
            m_ovr[d] = 1;
            if (m_cnt[d] < 65535) m_cnt[d]++;
          end
          mw[d][m_wptr[d]] = int'(a_s);
          m_off[d]  = m_wptr[d];
          m_wptr[d] = (m_wptr[d] + 1) % 64;
          m_ready[d] = 1;
          m_last[d] = cyc;
        end
        m_nval[d] = (m_nval[d] + 1) % DECV[d];
      end
    end
    if (rst) m_init = 1;
    cyc++;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_dut(input int d, input logic bsy, input logic rdy, input logic ovr,
                         input logic [5:0] off, input logic [15:0] cnt,
                         input logic signed [15:0] w [64]);
    string p;
    int bad;
    p = (d == 0) ? "dec1" : "dec4";
    chk({p, ".busy"}, bsy, (m_busy_left[d] > 0));
    chk({p, ".ready"}, rdy, m_ready[d]);
    chk({p, ".overrun"}, ovr, m_ovr[d]);
    chk({p, ".offset"}, off, m_off[d]);
`ifdef FIR_SAMPLE_RING_OVERRUN_CNT_EN
    chk({p, ".ovr_cnt"}, cnt, m_cnt[d]);
`else
    if (cnt != 16'd0) chk({p, ".ovr_cnt_absent"}, cnt, 0);
`endif
    if (m_busy_left[d] == 0) begin
      bad = -1;
      for (int i = 63; i >= 0; i--) if (int'(w[i]) != mw[d][i]) bad = i;
      chk({p, ".window_first_bad_idx"}, bad, -1);
    end
  endtask

  int rc1 = 0, rc4 = 0;
  logic [15:0] cnt1, cnt4;
`ifdef FIR_SAMPLE_RING_OVERRUN_CNT_EN
  assign cnt1 = if1.overrun_cnt_out;
  assign cnt4 = if4.overrun_cnt_out;
`else
  assign cnt1 = 16'd0;
  assign cnt4 = 16'd0;
`endif

  always @(negedge clk) begin
    if (if1.ready_out) rc1++;
    if (if4.ready_out) rc4++;
    if (m_init) begin
      cmp_dut(0, if1.busy_out, if1.ready_out, if1.overrun_out, if1.offset_out, cnt1, if1.sample_out);
      cmp_dut(1, if4.busy_out, if4.ready_out, if4.overrun_out, if4.offset_out, cnt4, if4.sample_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int val, input int gap, input bit chk_rdy);
    a_s = 16'(val); v_s = 1'b1;
    tick(1);
    v_s = 1'b0;
    if (chk_rdy) chk("lit.ready_latency", if1.ready_out, 1);
    tick(gap - 1);
  endtask

  function automatic int nonzero1();
    int n = 0;
    for (int i = 0; i < 64; i++) if (if1.sample_out[i] != 16'sd0) n++;
    return n;
  endfunction

  int rc4_base;

  initial begin
    rst = 1'b1; a_s = '0; v_s = 1'b0; f_s = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(63);
    chk("lit.busy_at_63", if1.busy_out, 1);
    tick(1);
    chk("lit.busy_at_64", if1.busy_out, 0);
    chk("lit.offset_after_flush", if1.offset_out, 63);
    chk("lit.no_ready_in_flush", rc1, 0);
    chk("lit.window_zero", nonzero1(), 0);

    send(100, 70, 1);
    send(200, 70, 1);
    send(300, 70, 1);
    chk("lit.s0", if1.sample_out[0], 100);
    chk("lit.s1", if1.sample_out[1], 200);
    chk("lit.s2", if1.sample_out[2], 300);
    chk("lit.offset_2", if1.offset_out, 2);
    chk("lit.ready_count_3", rc1, 3);
    chk("lit.no_overrun", if1.overrun_out, 0);

    send(500, 10, 0);
    send(600, 70, 1);
    chk("lit.overrun_set", if1.overrun_out, 1);
    chk("lit.late_written", if1.sample_out[4], 600);
    chk("lit.ready_count_5", rc1, 5);
`ifdef FIR_SAMPLE_RING_OVERRUN_CNT_EN
    chk("lit.ovr_cnt_1", if1.overrun_cnt_out, 1);
`endif

    f_s = 1'b1; v_s = 1'b1; a_s = 16'sh7FFF;
    tick(1);
    f_s = 1'b0; v_s = 1'b0;
    chk("lit.flush_busy", if1.busy_out, 1);
    chk("lit.flush_clears_ovr", if1.overrun_out, 0);
    tick(63);
    chk("lit.flush_busy_63", if1.busy_out, 1);
    tick(1);
    chk("lit.flush_done", if1.busy_out, 0);
    chk("lit.flush_window_zero", nonzero1(), 0);
    chk("lit.flush_dropped_ready", rc1, 5);

    for (int k = 0; k < 66; k++) send(k, 70, 0);
    chk("lit.wrap_e0", if1.sample_out[0], 64);
    chk("lit.wrap_e1", if1.sample_out[1], 65);
    chk("lit.wrap_e2", if1.sample_out[2], 2);
    chk("lit.wrap_offset", if1.offset_out, 1);

    f_s = 1'b1;
    tick(1);
    f_s = 1'b0;
    tick(66);
    rc4_base = rc4;
    for (int k = 0; k < 8; k++) send(1000 + k, 70, 0);
    chk("lit.dec4_pulses", rc4 - rc4_base, 2);
    chk("lit.dec4_e0", if4.sample_out[0], 1000);
    chk("lit.dec4_e1", if4.sample_out[1], 1004);
    chk("lit.dec4_offset", if4.offset_out, 1);

    rst = 1'b1; v_s = 1'b1; a_s = 16'sd77;
    tick(1);
    v_s = 1'b0;
    chk("lit.rst_no_ready", if1.ready_out, 0);
    chk("lit.rst_busy", if1.busy_out, 1);
    chk("lit.rst_offset", if1.offset_out, 0);
    rst = 1'b0;
    tick(70);
    chk("lit.rst_flush_done", if1.busy_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
